// File: rtl/flag_ctrl_if.sv
// flag_ctrl_if
//   Groups the condition-flag control signals exchanged between the pipeline
//   (EX/late-completion/ID stages) and the flag controller.
//   master : pipeline side; drives EX/late/ID requests and observes results.
//   slave  : flag controller; consumes requests, produces flags and control.
//   Signals:
//     ex_setflags, ex_valid, ex_late, ex_flags[3:0] : instruction in EX
//     late_valid, late_flags[3:0]                   : late-completing flags
//     flush                                         : pipeline squash
//     id_bcond, id_cond[3:0]                        : B.cond in ID
//     flags_q[3:0], flag_we, stall_id, br_taken, timeout : controller outputs
interface flag_ctrl_if;
  logic       ex_setflags;
  logic       ex_valid;
  logic       ex_late;
  logic [3:0] ex_flags;
  logic       late_valid;
  logic [3:0] late_flags;
  logic       flush;
  logic       id_bcond;
  logic [3:0] id_cond;
  logic [3:0] flags_q;
  logic       flag_we;
  logic       stall_id;
  logic       br_taken;
  logic       timeout;

  modport master (
    output ex_setflags, ex_valid, ex_late, ex_flags,
    output late_valid, late_flags, flush, id_bcond, id_cond,
    input  flags_q, flag_we, stall_id, br_taken, timeout
  );

  modport slave (
    input  ex_setflags, ex_valid, ex_late, ex_flags,
    input  late_valid, late_flags, flush, id_bcond, id_cond,
    output flags_q, flag_we, stall_id, br_taken, timeout
  );
endinterface

// File: rtl/flag_ctrl.sv
// flag_ctrl
//   Condition-flag storage and B.cond resolution for the pipelined LEGv8 core.
//   Single-cycle flag setters write at the edge after EX; late-completing ops
//   (multi-cycle multiply/shift) park the controller in WAIT_LATE until their
//   flags arrive, during which a B.cond in ID is stalled. In-flight flags are
//   bypassed to the branch evaluation. A watchdog bounds WAIT_LATE to MAX_WAIT
//   cycles and raises a sticky timeout if the late flags never show up.
//   Ports:
//     clk    : system clock, rising edge
//     reset  : asynchronous active-low reset
//     bus    : flag_ctrl_if.slave (EX/late/ID inputs, flag/stall/branch outputs)
//   Parameters:
//     MAX_WAIT : WAIT_LATE cycles before timeout (>= 1)
//     CW       : watchdog counter width (2**CW > MAX_WAIT)
module flag_ctrl #(
  parameter int MAX_WAIT = 8,
  parameter int CW       = 4
) (
  input  logic         clk,
  input  logic         reset,
  flag_ctrl_if.slave   bus
);

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LATE = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] wd_cnt;
  logic [3:0]    flags_r;
  logic          timeout_r;

  logic          setter;
  logic          in_idle;
  logic          in_wait;
  logic          early_wr;
  logic          late_wr;
  logic          start_late;
  logic          wr_en;
  logic [3:0]    wr_flags;
  logic [3:0]    eff_flags;
  logic          stall;
  logic          taken;

  localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

  // ARM condition evaluation over {N,Z,V,C}.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, v, c;
    logic r;
    n = f[3];
    z = f[2];
    v = f[1];
    c = f[0];
    case (cond)
      4'h0:    r = z;
      4'h1:    r = ~z;
      4'h2:    r = c;
      4'h3:    r = ~c;
      4'h4:    r = n;
      4'h5:    r = ~n;
      4'h6:    r = v;
      4'h7:    r = ~v;
      4'h8:    r = c & ~z;
      4'h9:    r = ~c | z;
      4'hA:    r = (n == v);
      4'hB:    r = (n != v);
      4'hC:    r = ~z & (n == v);
      4'hD:    r = z | (n != v);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  always_comb begin
    setter     = bus.ex_valid & bus.ex_setflags;
    in_idle    = (state == IDLE);
    in_wait    = (state == WAIT_LATE);

    early_wr   = in_idle & setter & ~bus.ex_late & ~bus.flush;
    // Flush wins over a coincident late_valid: the late op is squashed.
    late_wr    = in_wait & bus.late_valid & ~bus.flush;
    start_late = in_idle & setter & bus.ex_late & ~bus.flush;
    wr_en      = early_wr | late_wr;
    wr_flags   = in_wait ? bus.late_flags : bus.ex_flags;

    // Bypass choice ignores flush; a flushed branch is never taken anyway.
    if (in_idle & setter & ~bus.ex_late)
      eff_flags = bus.ex_flags;
    else if (in_wait & bus.late_valid)
      eff_flags = bus.late_flags;
    else
      eff_flags = flags_r;

    // A late op entering EX stalls the branch even before WAIT_LATE is
    // entered, since its flags cannot be known this cycle.
    stall = bus.id_bcond &
            ((in_wait & ~bus.late_valid & ~bus.flush) |
             (in_idle & setter & bus.ex_late));

    taken = bus.id_bcond & ~stall & ~bus.flush & cond_pass(bus.id_cond, eff_flags);
  end

  // Combinational outputs are forced low while reset is held so the pipeline
  // sees quiet control even with garbage on the inputs.
  assign bus.flag_we  = reset & wr_en;
  assign bus.stall_id = reset & stall;
  assign bus.br_taken = reset & taken;
  assign bus.flags_q  = flags_r;
  assign bus.timeout  = timeout_r;

  // Flag register, FSM and watchdog
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wd_cnt    <= '0;
      flags_r   <= 4'b0000;
      timeout_r <= 1'b0;
    end else begin
      if (wr_en)
        flags_r <= wr_flags;

      case (state)
        IDLE: begin
          // late_valid is meaningless here and is ignored.
          if (start_late) begin
            state  <= WAIT_LATE;
            wd_cnt <= CW'(1);
          end
        end
        WAIT_LATE: begin
          // New setters in EX cannot issue while waiting; they are ignored.
          if (bus.flush || bus.late_valid) begin
            state  <= IDLE;
            wd_cnt <= '0;
          end else if (wd_cnt == WAIT_LIMIT) begin
            state     <= IDLE;
            wd_cnt    <= '0;
            timeout_r <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + CW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          wd_cnt <= '0;
        end
      endcase
    end
  end

endmodule
